// File: rtl/cycle_timing_gen.sv
// Machine-cycle / beat generator for the control unit: one-hot cycle flags and beat,
// interrupt entry at instruction boundaries, HLT idling, and sequencing-fault watchdogs.
module cycle_timing_gen #(
  parameter int unsigned STALL_MAX = 16,
  parameter int unsigned STALL_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Tplus1,
  input  logic       Tset0,
  input  logic       Set_FI,
  input  logic       Set_DST,
  input  logic       Set_SRC,
  input  logic       Set_EXC,
  input  logic       Set_INT,
  input  logic       HALT,
  input  logic       int_req,
  input  logic       int_en,
  output logic       FI,
  output logic       DST,
  output logic       SRC,
  output logic       EXC,
  output logic       INT,
  output logic [7:0] T,
  output logic       int_ack,
  output logic       halted,
  output logic       seq_err,
  output logic       stall_err
);

  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

  typedef enum logic [2:0] {
    S_FI, S_DST, S_SRC, S_EXC, S_INT, S_HALT
  } cyc_t;

  cyc_t               cyc_q, cyc_nx;
  logic [7:0]         t_q, t_nx;
  logic               pend_q, pend_nx;
  logic               ack_q, ack_nx;
  logic               seq_q, err_ev;
  logic               stall_q, stall_nx;
  logic [STALL_W-1:0] cnt_q, cnt_nx;
  logic               pend_any, multi_set, any_set, changed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q   <= S_FI;
      t_q     <= 8'h01;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      seq_q   <= 1'b0;
      stall_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cyc_q   <= cyc_nx;
      t_q     <= t_nx;
      pend_q  <= pend_nx;
      ack_q   <= ack_nx;
      seq_q   <= seq_q | err_ev;
      stall_q <= stall_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_comb begin
    cyc_nx    = cyc_q;
    t_nx      = t_q;
    ack_nx    = 1'b0;
    err_ev    = 1'b0;
    pend_any  = pend_q | int_req;
    any_set   = Set_FI | Set_DST | Set_SRC | Set_EXC | Set_INT;
    multi_set = $countones({Set_FI, Set_DST, Set_SRC, Set_EXC, Set_INT}) > 1;

    if (cyc_q == S_HALT) begin
      // A request arriving on this very edge is enough to wake the core.
      if (pend_any && int_en) begin
        cyc_nx = S_INT;
        t_nx   = 8'h01;
        ack_nx = 1'b1;
      end
    end else if (any_set) begin
      err_ev = multi_set;
      t_nx   = 8'h01;
      if (Set_FI) begin
        if (HALT) begin
          cyc_nx = S_HALT;
          t_nx   = 8'h00;
        end else if (pend_q && int_en) begin
          cyc_nx = S_INT;
          ack_nx = 1'b1;
        end else begin
          cyc_nx = S_FI;
        end
      end else if (Set_EXC) begin
        cyc_nx = S_EXC;
      end else if (Set_SRC) begin
        cyc_nx = S_SRC;
      end else if (Set_DST) begin
        cyc_nx = S_DST;
      end else begin
        cyc_nx = S_INT;
        ack_nx = 1'b1;
      end
    end else if (Tset0) begin
      t_nx = 8'h01;
    end else if (Tplus1) begin
      if (t_q == 8'h80) err_ev = 1'b1;
      else              t_nx   = {t_q[6:0], 1'b0};
    end

    pend_nx = ack_nx ? 1'b0 : pend_any;

    changed = (cyc_nx != cyc_q) || (t_nx != t_q);
    if (changed)               cnt_nx = '0;
    else if (cyc_q == S_HALT)  cnt_nx = cnt_q;
    else if (cnt_q == STALL_LIM) cnt_nx = cnt_q;
    else                       cnt_nx = cnt_q + 1'b1;
    stall_nx = stall_q | (cnt_nx == STALL_LIM);
  end

  always_comb begin
    FI        = 1'b0;
    DST       = 1'b0;
    SRC       = 1'b0;
    EXC       = 1'b0;
    INT       = 1'b0;
    halted    = 1'b0;
    case (cyc_q)
      S_FI:    FI     = 1'b1;
      S_DST:   DST    = 1'b1;
      S_SRC:   SRC    = 1'b1;
      S_EXC:   EXC    = 1'b1;
      S_INT:   INT    = 1'b1;
      default: halted = 1'b1;
    endcase
    T         = t_q;
    int_ack   = ack_q;
    seq_err   = seq_q;
    stall_err = stall_q;
  end

endmodule
